mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one MemIntf-style memory port between p_num_clients requesters, e.g. LoadStoreUnit instances and fetch.
- Arbitrates requests round-robin and forwards the winning request unchanged to memory.
- Records the winner's client ID in an in-order tracking FIFO, which routes each memory response back to the client that issued the request.
- Memory returns responses in request order.

Parameters:
- p_num_clients, 2, number of requesting clients (≥2)
- p_req_bits, 77, width of one packed request message (op, opaque, addr, len, data); not interpreted by the arbiter
- p_resp_bits, 45, width of one packed response message; not interpreted by the arbiter
- p_max_inflight, 4, tracking FIFO depth, i.e. the maximum number of outstanding requests (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cl_req_val  in  p_num_clients  per-client request valid
- cl_req_rdy  out  p_num_clients  per-client request ready (grant)
- cl_req_msg  in  p_num_clients*p_req_bits  flattened requests; client i occupies bits [i*p_req_bits +: p_req_bits]
- cl_resp_val  out  p_num_clients  per-client response valid
- cl_resp_rdy  in  p_num_clients  per-client response ready
- cl_resp_msg  out  p_resp_bits  response message, broadcast to all clients
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_req_msg  out  p_req_bits  memory request message
- mem_resp_val  in  1  memory response valid
- mem_resp_rdy  out  1  memory response ready
- mem_resp_msg  in  p_resp_bits  memory response message

Behaviour:
- Interface: one clock, clk; rst is asynchronous, active-high.
- State: priority pointer ptr (clog2(p_num_clients) bits); tracking FIFO of client IDs (head, tail, count, count range 0..p_max_inflight).
- Reset: ptr=0, count=0, head=tail=0.
- While rst is high, all val/rdy outputs are forced to 0: cl_req_rdy, cl_resp_val, mem_req_val, mem_resp_rdy.
- Request eligibility: can_issue = (count < p_max_inflight).
- Winner selection: the first i with cl_req_val[i]=1, scanning from ptr upward modulo p_num_clients.
- Request path (combinational, zero added latency):
  - mem_req_val = can_issue & any(cl_req_val).
  - mem_req_msg = winner's message.
  - cl_req_rdy[winner] = can_issue & mem_req_rdy; all other bits are 0.
  - mem_req_msg is don't-care when mem_req_val=0.
- On a request transfer (mem_req_val & mem_req_rdy):
  - Push the winner ID at tail; tail wraps modulo p_max_inflight.
  - ptr <= (winner+1) mod p_num_clients.
  - With no transfer, ptr holds.
- Full FIFO: no requests are accepted, even if a response pops in the same cycle. There is no resp->req combinational path.
- Response path (combinational):
  - id = FIFO head entry.
  - mem_resp_rdy = (count>0) & cl_resp_rdy[id].
  - cl_resp_val[id] = mem_resp_val & (count>0); all other bits are 0.
  - cl_resp_msg = mem_resp_msg.
- On a response transfer: pop head; head wraps modulo p_max_inflight.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Push into an empty FIFO with a response arriving in the same cycle: the response is not accepted (count was 0). This avoids same-cycle req->resp routing.
- mem_resp_val while count==0 is a protocol error:
  - mem_resp_rdy stays 0.
  - Under `ifndef SYNTHESIS`, an error is reported via $error.
- Reset mid-operation: all outstanding tracking is discarded. Memory and clients are reset together.
- The arbiter holds no message storage. Requesters must hold val and msg stable until rdy, per the valid/ready rules.
- Starvation bound: a waiting client is granted within p_num_clients request transfers.
- Linetrace (non-synthesis): the function trace() returns "<winner>><count>" on a request transfer, otherwise spaces of equal width.

Optional Feature:
- Macro: MEM_ARBITER_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index requesting client; ptr is not implemented (removed, or tied to 0); everything else is unchanged. The starvation bound does not apply.
- Undefined: round-robin as specified above.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle -> all val/rdy outputs are 0 immediately; after release, with no requests, mem_req_val=0 and count=0.
- Round-robin: clients 0 and 1 request continuously, mem_req_rdy=1, responses returned immediately -> grants alternate 0,1,0,1.
  - With MEM_ARBITER_FIXED_PRIO_EN: grants are 0,0,0,0.
- Full FIFO: p_max_inflight=4, 5 requests, no responses -> 4 accepted, then mem_req_val=0 and cl_req_rdy=0. One response pops -> next request accepted the following cycle, not the same cycle.
- Response routing: issue requests in order client 1, 0, 1 with addresses 0x100, 0x200, 0x300 -> responses are delivered to cl_resp_val[1], [0], [1] in order, and cl_resp_msg matches mem_resp_msg.
- Backpressure: cl_resp_rdy[1]=0 while the head entry is client 1 -> mem_resp_rdy=0 and the response stalls. A pending response for client 0 is not delivered out of order.
- Wrap and stray response: run 10 request/response pairs so the pointers wrap twice -> routing stays correct. Then drive mem_resp_val with count=0 -> mem_resp_rdy=0 and $error fires.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N:1 memory request arbiter with in-order response routing.
// Optional macro MEM_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority.
module mem_arbiter #(
  parameter int p_num_clients  = 2,
  parameter int p_req_bits     = 77,
  parameter int p_resp_bits    = 45,
  parameter int p_max_inflight = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_clients-1:0]              cl_req_val,
  output logic [p_num_clients-1:0]              cl_req_rdy,
  input  logic [p_num_clients*p_req_bits-1:0]   cl_req_msg,
  output logic [p_num_clients-1:0]              cl_resp_val,
  input  logic [p_num_clients-1:0]              cl_resp_rdy,
  output logic [p_resp_bits-1:0]                cl_resp_msg,
  output logic                                  mem_req_val,
  input  logic                                  mem_req_rdy,
  output logic [p_req_bits-1:0]                 mem_req_msg,
  input  logic                                  mem_resp_val,
  output logic                                  mem_resp_rdy,
  input  logic [p_resp_bits-1:0]                mem_resp_msg
);

  localparam int PW = (p_num_clients > 1) ? $clog2(p_num_clients) : 1;
  localparam int IW = $clog2(p_max_inflight);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] MAXC = CW'(p_max_inflight);
  localparam logic [PW-1:0] LASTC = PW'(p_num_clients - 1);
  localparam logic [p_num_clients-1:0] ONE = p_num_clients'(1);

  logic [PW-1:0] base;
  logic [PW-1:0] win;
  logic          any;
  logic          can_issue;
  logic          nonempty;
  logic          req_xfer;
  logic          resp_xfer;
  logic [PW-1:0] head_id;

  logic [PW-1:0] fifo_q [p_max_inflight];
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;
  assign base = ptr_q;
`endif

  // Pick the first requester at or above the priority base, wrapping around.
  always_comb begin
    int            j;
    logic [PW-1:0] idx;
    win = '0;
    any = 1'b0;
    j   = 0;
    idx = '0;
    for (int k = p_num_clients - 1; k >= 0; k--) begin
      j = int'(base) + k;
      if (j >= p_num_clients) j = j - p_num_clients;
      idx = PW'(j);
      if (cl_req_val[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

  assign can_issue = (cnt_q < MAXC);
  assign nonempty  = (cnt_q != '0);
  assign head_id   = fifo_q[head_q];

  assign mem_req_val = ~rst & can_issue & any;
  assign req_xfer    = mem_req_val & mem_req_rdy;
  assign mem_req_msg = cl_req_msg[int'(win)*p_req_bits +: p_req_bits];
  assign cl_req_rdy  = req_xfer ? (ONE << win) : '0;

  assign mem_resp_rdy = ~rst & nonempty & cl_resp_rdy[head_id];
  assign resp_xfer    = mem_resp_val & mem_resp_rdy;
  assign cl_resp_val  = (~rst & mem_resp_val & nonempty) ? (ONE << head_id) : '0;
  assign cl_resp_msg  = mem_resp_msg;

  // Tracking pointers and occupancy advance on request push / response pop.
  always_comb begin
    head_d = head_q + IW'(resp_xfer);
    tail_d = tail_q + IW'(req_xfer);
    cnt_d  = cnt_q + CW'(req_xfer) - CW'(resp_xfer);
  end

  // Tracking state register; reset discards all outstanding entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Client-ID storage; contents only matter while counted as valid.
  always_ff @(posedge clk) begin
    if (req_xfer) fifo_q[tail_q] <= win;
  end

`ifndef MEM_ARBITER_FIXED_PRIO_EN
  // Priority moves just past the last winner so every waiter gets a turn.
  always_comb begin
    ptr_d = ptr_q;
    if (req_xfer) ptr_d = (win == LASTC) ? '0 : win + PW'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding cannot be routed anywhere.
  always_ff @(posedge clk) begin
    if (!rst && mem_resp_val && cnt_q == '0)
      $error("mem_arbiter: memory response with no outstanding request");
  end

  function automatic string trace();
    string s;
    string b;
    s = $sformatf("%0d>%0d", win, cnt_q);
    b = "";
    if (!req_xfer) begin
      for (int i = 0; i < s.len(); i++) b = {b, " "};
      s = b;
    end
    return s;
  endfunction
`endif

endmodule
